// File: rtl/shift_execute_stage.sv
// Two-stage MIPS shift execute unit (sll/srl/sra and variable forms) with valid/ready flow control.
// S1 latches the decoded operation, S2 latches the result; only DATA_W=32 is supported.
module shift_execute_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_funct,
  input  logic [4:0]        in_shamt,
  input  logic [DATA_W-1:0] in_rs,
  input  logic [DATA_W-1:0] in_rt,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_illegal
);

  logic              r_s1Valid;
  logic [DATA_W-1:0] r_s1Value;
  logic [4:0]        r_s1Amt;
  logic              r_s1Right;
  logic              r_s1Arith;
  logic [RD_W-1:0]   r_s1Rd;
  logic              r_s1Illegal;

  logic              r_s2Valid;
  logic [DATA_W-1:0] r_s2Result;
  logic [RD_W-1:0]   r_s2Rd;
  logic              r_s2Illegal;

  logic              w_s2Ready;
  logic              w_useVar;
  logic              w_right;
  logic              w_arith;
  logic              w_illegal;
  logic [4:0]        w_amount;
  logic [DATA_W-1:0] w_revIn;
  logic [DATA_W-1:0] w_fillMask;
  logic [DATA_W-1:0] w_shl;
  logic [DATA_W-1:0] w_revOut;
  logic [DATA_W-1:0] w_result;

  assign w_s2Ready = !r_s2Valid || out_ready;
  assign in_ready  = !r_s1Valid || w_s2Ready;

  always_comb begin
    w_useVar  = 1'b0;
    w_right   = 1'b0;
    w_arith   = 1'b0;
    w_illegal = 1'b0;
    case (in_funct)
      6'b000000: ;
      6'b000010: w_right = 1'b1;
      6'b000011: begin w_right = 1'b1; w_arith = 1'b1; end
      6'b000100: w_useVar = 1'b1;
      6'b000110: begin w_useVar = 1'b1; w_right = 1'b1; end
      6'b000111: begin w_useVar = 1'b1; w_right = 1'b1; w_arith = 1'b1; end
      default:   w_illegal = 1'b1;
    endcase
    w_amount = w_useVar ? in_rs[4:0] : in_shamt;
  end

  // Right shifts reuse the left shifter on the bit-reversed value; the sign fill
  // enters at the LSB of the reversed word, which becomes the MSB after reversal.
  always_comb begin
    w_revIn  = '0;
    w_revOut = '0;
    for (int i = 0; i < DATA_W; i++) begin
      w_revIn[i] = r_s1Value[DATA_W-1-i];
    end
    w_fillMask = ~({DATA_W{1'b1}} << r_s1Amt);
    w_shl      = ((r_s1Right ? w_revIn : r_s1Value) << r_s1Amt)
               | ((r_s1Arith && r_s1Value[DATA_W-1]) ? w_fillMask : '0);
    for (int i = 0; i < DATA_W; i++) begin
      w_revOut[i] = w_shl[DATA_W-1-i];
    end
    w_result = r_s1Illegal ? '0 : (r_s1Right ? w_revOut : w_shl);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_s1Valid   <= 1'b0;
      r_s1Value   <= '0;
      r_s1Amt     <= '0;
      r_s1Right   <= 1'b0;
      r_s1Arith   <= 1'b0;
      r_s1Rd      <= '0;
      r_s1Illegal <= 1'b0;
    end else if (in_ready) begin
      r_s1Valid <= in_valid;
      if (in_valid) begin
        r_s1Value   <= in_rt;
        r_s1Amt     <= w_amount;
        r_s1Right   <= w_right;
        r_s1Arith   <= w_arith;
        r_s1Rd      <= in_rd;
        r_s1Illegal <= w_illegal;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_s2Valid   <= 1'b0;
      r_s2Result  <= '0;
      r_s2Rd      <= '0;
      r_s2Illegal <= 1'b0;
    end else if (w_s2Ready) begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_s2Result  <= w_result;
        r_s2Rd      <= r_s1Rd;
        r_s2Illegal <= r_s1Illegal;
      end
    end
  end

  assign out_valid   = r_s2Valid;
  assign out_result  = r_s2Result;
  assign out_rd      = r_s2Rd;
  assign out_illegal = r_s2Illegal;

endmodule

// File: tb/tb_shift_execute_stage.sv
// Self-checking bench for shift_execute_stage: vector table, hand-written
// flow-control/reset sequences and a randomized run, all through a scoreboard queue.
module tb_shift_execute_stage;

  typedef struct {
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  rd;
  } op_t;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        illegal;
  } exp_t;

  typedef struct {
    op_t  op;
    exp_t e;
  } vec_t;

  logic        clock;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_funct;
  logic [4:0]  in_shamt;
  logic [31:0] in_rs;
  logic [31:0] in_rt;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_illegal;

  int   compared   = 0;
  int   mismatched = 0;
  int   popCount   = 0;
  logic sampInReady;
  logic sampOutValid;
  exp_t sbQ[$];

  shift_execute_stage #(.DATA_W(32), .RD_W(5)) dut (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_funct(in_funct), .in_shamt(in_shamt), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_illegal(out_illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Independent reference built from the native shift operators.
  function automatic exp_t refModel(input op_t op);
    exp_t e;
    e.rd      = op.rd;
    e.illegal = 1'b0;
    case (op.funct)
      6'b000000: e.result = op.rt << op.shamt;
      6'b000010: e.result = op.rt >> op.shamt;
      6'b000011: e.result = $unsigned($signed(op.rt) >>> op.shamt);
      6'b000100: e.result = op.rt << op.rs[4:0];
      6'b000110: e.result = op.rt >> op.rs[4:0];
      6'b000111: e.result = $unsigned($signed(op.rt) >>> op.rs[4:0]);
      default: begin e.result = 32'h0; e.illegal = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sbQ.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL unexpectedOutput: got result 0x%08h rd %0d with empty scoreboard", out_result, out_rd);
    end else begin
      e = sbQ.pop_front();
      checkVal("result", out_result, e.result);
      checkVal("rd", {27'h0, out_rd}, {27'h0, e.rd});
      checkVal("illegal", {31'h0, out_illegal}, {31'h0, e.illegal});
    end
    popCount++;
  endtask

  // One cycle: drive at negedge, sample after settling, let the next posedge transfer.
  task automatic stepCycle(input logic v, input op_t op, input logic rdy, input exp_t e, output logic acc);
    @(negedge clock);
    in_valid  = v;
    in_funct  = op.funct;
    in_shamt  = op.shamt;
    in_rs     = op.rs;
    in_rt     = op.rt;
    in_rd     = op.rd;
    out_ready = rdy;
    #1;
    sampInReady  = in_ready;
    sampOutValid = out_valid;
    acc = v && in_ready;
    if (acc) sbQ.push_back(e);
    if (out_valid && out_ready) checkOutput();
    @(posedge clock);
  endtask

  task automatic idleCycle(input logic rdy);
    op_t  z;
    exp_t ze;
    logic acc;
    z  = '{funct: 6'h0, shamt: 5'h0, rs: 32'h0, rt: 32'h0, rd: 5'h0};
    ze = '{result: 32'h0, rd: 5'h0, illegal: 1'b0};
    stepCycle(1'b0, z, rdy, ze, acc);
  endtask

  task automatic applyStimulus(input op_t op, input exp_t e, input logic rdy);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      stepCycle(1'b1, op, rdy, e, acc);
      n++;
    end
    if (!acc) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL acceptTimeout: got no acceptance, want acceptance within 200 cycles");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbQ.size() > 0 && n < 200) begin
      idleCycle(1'b1);
      n++;
    end
    if (sbQ.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drainTimeout: got %0d pending, want 0", sbQ.size());
    end
    repeat (3) idleCycle(1'b1);
  endtask

  initial begin
    vec_t vecs[13];
    op_t  opA, opB, opC, cur;
    exp_t eA, eB, eC, e;
    logic acc, haveOp, v, rdy;
    int   popsBefore, accepted, cyc;

    vecs[0]  = '{op: '{6'b000000, 5'd31, 32'h0, 32'h0000_0001, 5'd3},  e: '{32'h8000_0000, 5'd3, 1'b0}};
    vecs[1]  = '{op: '{6'b000011, 5'd4, 32'h0, 32'h8000_0000, 5'd4},   e: '{32'hF800_0000, 5'd4, 1'b0}};
    vecs[2]  = '{op: '{6'b000010, 5'd4, 32'h0, 32'h8000_0000, 5'd5},   e: '{32'h0800_0000, 5'd5, 1'b0}};
    vecs[3]  = '{op: '{6'b000111, 5'd9, 32'hFFFF_FFE1, 32'h8000_0001, 5'd6}, e: '{32'hC000_0000, 5'd6, 1'b0}};
    vecs[4]  = '{op: '{6'b000100, 5'd0, 32'h0000_0004, 32'h0000_00F1, 5'd7}, e: '{32'h0000_0F10, 5'd7, 1'b0}};
    vecs[5]  = '{op: '{6'b000110, 5'd7, 32'h0000_0020, 32'hDEAD_BEEF, 5'd8}, e: '{32'hDEAD_BEEF, 5'd8, 1'b0}};
    vecs[6]  = '{op: '{6'b000011, 5'd0, 32'h0, 32'h8000_0000, 5'd9},   e: '{32'h8000_0000, 5'd9, 1'b0}};
    vecs[7]  = '{op: '{6'b100000, 5'd2, 32'h1, 32'h1234_5678, 5'd10},  e: '{32'h0000_0000, 5'd10, 1'b1}};
    vecs[8]  = '{op: '{6'b000000, 5'd0, 32'h0, 32'hA5A5_A5A5, 5'd11},  e: '{32'hA5A5_A5A5, 5'd11, 1'b0}};
    vecs[9]  = '{op: '{6'b000010, 5'd31, 32'h0, 32'h8000_0000, 5'd12}, e: '{32'h0000_0001, 5'd12, 1'b0}};
    vecs[10] = '{op: '{6'b000011, 5'd31, 32'h0, 32'h8000_0000, 5'd13}, e: '{32'hFFFF_FFFF, 5'd13, 1'b0}};
    vecs[11] = '{op: '{6'b000111, 5'd0, 32'h0000_001F, 32'h7FFF_FFFF, 5'd14}, e: '{32'h0000_0000, 5'd14, 1'b0}};
    vecs[12] = '{op: '{6'b000001, 5'd1, 32'h0, 32'hFFFF_FFFF, 5'd15}, e: '{32'h0000_0000, 5'd15, 1'b1}};

    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_funct = '0; in_shamt = '0; in_rs = '0; in_rt = '0; in_rd = '0;

    // Reset state, then first acceptance on the very first edge after release.
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkVal("rstOutValid", {31'h0, out_valid}, 32'h0);
    checkVal("rstOutResult", out_result, 32'h0);
    checkVal("rstInReady", {31'h0, in_ready}, 32'h1);
    @(posedge clock);
    #1 resetn = 1'b1;

    // Single sll with latency check.
    opA = vecs[0].op;
    eA  = vecs[0].e;
    stepCycle(1'b1, opA, 1'b0, eA, acc);
    checkVal("firstAccept", {31'h0, acc}, 32'h1);
    idleCycle(1'b0);
    checkVal("latencyCycle1", {31'h0, sampOutValid}, 32'h0);
    idleCycle(1'b0);
    checkVal("latencyCycle2", {31'h0, sampOutValid}, 32'h1);
    drain();

    // Vector table, streamed back to back.
    for (int i = 0; i < 13; i++) applyStimulus(vecs[i].op, vecs[i].e, 1'b1);
    drain();

    // Back-pressure: A, B, C with the output stalled for 3 cycles after A reaches S2.
    opA = '{6'b000000, 5'd1, 32'h0, 32'h0000_0003, 5'd1};  eA = refModel(opA);
    opB = '{6'b000010, 5'd2, 32'h0, 32'hF000_0000, 5'd2};  eB = refModel(opB);
    opC = '{6'b000111, 5'd0, 32'h0000_0003, 32'h8000_0000, 5'd30}; eC = refModel(opC);
    applyStimulus(opA, eA, 1'b0);
    applyStimulus(opB, eB, 1'b0);
    for (int i = 0; i < 3; i++) begin
      stepCycle(1'b1, opC, 1'b0, eC, acc);
      checkVal("stallOutValid", {31'h0, sampOutValid}, 32'h1);
      checkVal("stallHoldResult", out_result, eA.result);
      checkVal("stallInReady", {31'h0, sampInReady}, 32'h0);
    end
    popsBefore = popCount;
    stepCycle(1'b1, opC, 1'b1, eC, acc);
    checkVal("releaseAcceptC", {31'h0, acc}, 32'h1);
    idleCycle(1'b1);
    idleCycle(1'b1);
    checkVal("consecutivePops", popCount - popsBefore, 32'd3);
    drain();

    // Reset asserted with both stages full: everything in flight is discarded.
    applyStimulus(opA, eA, 1'b0);
    applyStimulus(opB, eB, 1'b0);
    @(negedge clock);
    in_valid = 1'b0;
    resetn   = 1'b0;
    #1;
    checkVal("midRstOutValid", {31'h0, out_valid}, 32'h0);
    checkVal("midRstResult", out_result, 32'h0);
    checkVal("midRstRd", {27'h0, out_rd}, 32'h0);
    checkVal("midRstIllegal", {31'h0, out_illegal}, 32'h0);
    checkVal("midRstInReady", {31'h0, in_ready}, 32'h1);
    sbQ.delete();
    @(posedge clock);
    #1 resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idleCycle(1'b1);
      checkVal("noStaleAfterRst", {31'h0, sampOutValid}, 32'h0);
    end

    // Randomized valid/ready on both sides against the reference model.
    popsBefore = popCount;
    accepted   = 0;
    cyc        = 0;
    haveOp     = 1'b0;
    cur        = '{6'h0, 5'h0, 32'h0, 32'h0, 5'h0};
    while (accepted < 10000 && cyc < 80000) begin
      v = haveOp ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (v && !haveOp) begin
        case ($urandom_range(0, 7))
          0: cur.funct = 6'b000000;
          1: cur.funct = 6'b000010;
          2: cur.funct = 6'b000011;
          3: cur.funct = 6'b000100;
          4: cur.funct = 6'b000110;
          5: cur.funct = 6'b000111;
          default: cur.funct = 6'($urandom);
        endcase
        cur.shamt = 5'($urandom);
        cur.rs    = $urandom;
        cur.rt    = $urandom;
        cur.rd    = 5'($urandom);
      end
      haveOp = v;
      rdy = ($urandom_range(0, 3) != 0);
      e   = refModel(cur);
      stepCycle(v, cur, rdy, e, acc);
      if (acc) begin
        accepted++;
        haveOp = 1'b0;
      end
      cyc++;
    end
    checkVal("randomAccepted", accepted, 32'd10000);
    drain();
    checkVal("randomPops", popCount - popsBefore, 32'd10000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/shift_execute_stage.md
SHIFT_EXECUTE_STAGE -- requirements
Module: shift_execute_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath width; this version SHALL support only 32.
REQ-002 Parameter RD_W, default 5, destination register address width.
REQ-003 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 resetn  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  upstream holds a valid shift operation.
REQ-006 in_ready  output  1  stage accepts an operation this cycle.
REQ-007 in_funct  input  6  MIPS funct field.
REQ-008 in_shamt  input  5  immediate shift amount.
REQ-009 in_rs  input  32  variable-amount source; only bits [4:0] are used.
REQ-010 in_rt  input  32  value to be shifted.
REQ-011 in_rd  input  5  destination register address.
REQ-012 out_valid  output  1  result held for downstream.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 out_result  output  32  shifted value.
REQ-015 out_rd  output  5  destination address carried with the result.
REQ-016 out_illegal  output  1  funct was not a supported shift.

Function
REQ-017 Supported funct codes SHALL be: sll 000000, srl 000010, sra 000011, sllv 000100, srlv 000110, srav 000111.
REQ-018 Amount SHALL be in_shamt for sll/srl/sra, and in_rs[4:0] for sllv/srlv/srav.
REQ-019 Pipeline SHALL have two registered stages: S1 (decode: value, amount, direction, arithmetic flag, rd, illegal) and S2 (result).
REQ-020 Each stage SHALL hold a valid bit; a transfer SHALL occur on an edge where valid and ready are both 1.
REQ-021 s2_ready SHALL equal !s2_valid || out_ready; in_ready SHALL equal !s1_valid || s2_ready, combinationally.
REQ-022 With no back-pressure, latency SHALL be 2 cycles from input transfer to out_valid, at a throughput of 1 op/cycle.
REQ-023 Left shifts SHALL zero-fill from the LSB.
REQ-024 Right shifts SHALL be computed as bit-reverse, left shift, bit-reverse.
REQ-025 srl/srlv SHALL fill with 0; sra/srav SHALL fill with in_rt[31].
REQ-026 Amount 0 SHALL pass the value unchanged for all six ops.
REQ-027 An unsupported funct SHALL still flow through the pipeline, with out_result=0 and out_illegal=1; a supported funct SHALL give out_illegal=0.
REQ-028 While out_valid=1 and out_ready=0, out_result, out_rd and out_illegal SHALL hold stable, and S1 SHALL hold when full.
REQ-029 When S2 is full, out_ready=1 and S1 is valid, S2 SHALL reload from S1 on the same edge, with no bubble.
REQ-030 When S1 is full, S2 accepts and in_valid=1, S1 SHALL reload on the same edge.
REQ-031 No operation SHALL be dropped or duplicated under any valid/ready pattern.

Reset
REQ-032 When resetn=0, s1_valid and s2_valid SHALL clear immediately.
REQ-033 When resetn=0, out_valid=0, out_result=0, out_rd=0 and out_illegal=0 SHALL hold until the first edge after release.
REQ-034 Operations in flight when reset asserts mid-operation SHALL be discarded.
REQ-035 in_ready SHALL read 1 while in reset.
REQ-036 First acceptance SHALL be possible on the first edge with resetn=1.

Verification
REQ-037 sll, rt=0x0000_0001, shamt=31, out_ready=1 -> out_result=0x8000_0000, out_rd echoed, out_valid exactly 2 cycles after accept.
REQ-038 sra, rt=0x8000_0000, shamt=4 -> 0xF800_0000; srl, same operands -> 0x0800_0000; srav, rs=0xFFFF_FFE1 (amount 1), rt=0x8000_0001 -> 0xC000_0000.
REQ-039 Back-to-back ops A, B, C with out_ready low for 3 cycles after A reaches S2 -> A held stable, in_ready=0 once S1 is full; after release A, B, C emerge in order on consecutive cycles.
REQ-040 funct=100000 (add), rt=0x1234_5678 -> out_result=0, out_illegal=1, out_rd echoed; the next valid sll gives out_illegal=0.
REQ-041 resetn pulsed low while both stages are full -> out_valid=0 and all outputs 0 immediately; no stale result appears after release.
REQ-042 Randomized valid/ready on both sides over 10k ops against a reference model -> every result matches, in order, with none lost.
